// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, run/lap/pause FSM and 10 ms tick divider.
// Drives the BCD counter enable/clear and the display freeze latch.
`timescale 1ns/1ps
module stopwatch_ctrl #(
    parameter int TICK_DIV     = 1_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_startstop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       count_en,
    output logic       count_clr,
    output logic       disp_freeze,
    output logic       running,
    output logic [1:0] state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_TOP  = DW'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] LAP   = 2'b10;
    localparam logic [1:0] PAUSE = 2'b11;

    // bit 0 startstop, bit 1 clear, bit 2 lap
    logic [2:0]    btn;
    logic [2:0]    meta;
    logic [2:0]    sync;
    logic [2:0]    prev;
    logic [2:0]    db;
    logic [2:0]    db_q;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];

    logic          clr_p;
    logic          ss_p;
    logic          lap_p;
    logic [1:0]    nxt;
    logic          nxt_run;
    logic [PW-1:0] pre;

    assign btn = {btn_lap, btn_clear, btn_startstop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
            db_q <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync[i] != prev[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_TOP) begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
                if (sync[i] == prev[i] && db_cnt[i] == DB_TOP) begin
                    db[i] <= sync[i];
                end
            end
        end
    end

    assign press = db & ~db_q;
    assign clr_p = press[1];
    assign ss_p  = press[0] & ~press[1];
    assign lap_p = press[2] & ~press[1] & ~press[0];

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (ss_p) nxt = RUN;
            RUN:     if (ss_p) nxt = PAUSE;
                     else if (lap_p) nxt = LAP;
            LAP:     if (ss_p) nxt = PAUSE;
                     else if (lap_p) nxt = RUN;
            PAUSE:   if (ss_p) nxt = RUN;
            default: nxt = IDLE;
        endcase
        if (clr_p) nxt = IDLE;
    end

    assign nxt_run     = (nxt == RUN) || (nxt == LAP);
    assign running     = (state == RUN) || (state == LAP);
    assign disp_freeze = (state == LAP);

    // A wrap that coincides with leaving RUN/LAP is parked at the top
    // so the tick fires right after resume instead of landing in PAUSE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pre       <= '0;
            count_en  <= 1'b0;
            count_clr <= 1'b0;
        end else begin
            state     <= nxt;
            count_clr <= clr_p;
            count_en  <= 1'b0;
            if (clr_p || state == IDLE) begin
                pre <= '0;
            end else if (running) begin
                if (pre != PRE_TOP) begin
                    pre <= pre + PW'(1);
                end else if (nxt_run) begin
                    pre      <= '0;
                    count_en <= 1'b1;
                end
            end
        end
    end

endmodule
